// File: rtl/led_mode_controller_pkg.sv
// rtl/led_mode_controller_pkg.sv - shared types and entry values for the LED mode sequencer
package led_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_MIRROR = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_BLINK  = 2'd2,
        MODE_COUNT  = 2'd3
    } mode_t;

    localparam int   CHASE_SEED       = 1;
    localparam logic BLINK_PHASE_INIT = 1'b1;

endpackage

// File: rtl/led_mode_controller_if.sv
// rtl/led_mode_controller_if.sv - switch/key inputs and LED outputs of the mode sequencer
interface led_mode_controller_if
    import led_ctrl_pkg::*;
#(
    parameter int WIDTH = 10
) ();

    logic [WIDTH-1:0] sw_data;
    mode_t            mode;
    logic             auto_en;
    logic             step_btn_n;
    logic [WIDTH-1:0] led;
    logic             tick;

    modport master (
        output sw_data,
        output mode,
        output auto_en,
        output step_btn_n,
        input  led,
        input  tick
    );

    modport slave (
        input  sw_data,
        input  mode,
        input  auto_en,
        input  step_btn_n,
        output led,
        output tick
    );

endinterface

// File: rtl/led_mode_controller_prescaler.sv
// rtl/led_mode_controller_prescaler.sv - auto-advance prescaler, one tick per TICK_DIV enabled cycles
module tick_prescaler #(
    parameter int TICK_DIV = 12_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    // Gated by en so the cycle in which auto_en drops cannot emit a stray tick.
    assign tick = en && (count == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n || clr || !en) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/led_mode_controller.sv
// rtl/led_mode_controller.sv - drives the LED bank from the switches in mirror/chase/blink/count modes
module led_mode_controller
    import led_ctrl_pkg::*;
#(
    parameter int WIDTH    = 10,
    parameter int TICK_DIV = 12_500_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    led_mode_controller_if.slave bus
);

    mode_t            mode_q;
    logic [WIDTH-1:0] pattern;
    logic             phase;
    logic             sync1;
    logic             sync2;
    logic             sync3;
    logic             tick_raw;
    logic             step_pulse;
    logic             advance;
    logic             mode_change;

    assign step_pulse  = sync3 & ~sync2;
    assign advance     = tick_raw | step_pulse;
    assign mode_change = (bus.mode != mode_q);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (bus.auto_en),
        .clr   (mode_change),
        .tick  (tick_raw)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q   <= MODE_MIRROR;
            pattern  <= '0;
            phase    <= BLINK_PHASE_INIT;
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            sync3    <= 1'b1;
            bus.led  <= '0;
            bus.tick <= 1'b0;
        end else begin
            sync1    <= bus.step_btn_n;
            sync2    <= sync1;
            sync3    <= sync2;
            bus.tick <= tick_raw;

            // A mode switch owns the cycle: entry value wins over any coincident advance.
            if (mode_change) begin
                mode_q <= bus.mode;
                phase  <= BLINK_PHASE_INIT;
                case (bus.mode)
                    MODE_CHASE: pattern <= WIDTH'(CHASE_SEED);
                    MODE_BLINK: pattern <= bus.sw_data;
                    default:    pattern <= '0;
                endcase
            end else if (advance) begin
                case (mode_q)
                    MODE_CHASE: begin
                        if (bus.sw_data[WIDTH-1]) begin
                            pattern <= {pattern[0], pattern[WIDTH-1:1]};
                        end else begin
                            pattern <= {pattern[WIDTH-2:0], pattern[WIDTH-1]};
                        end
                    end
                    MODE_BLINK:  phase   <= ~phase;
                    MODE_COUNT:  pattern <= pattern + 1'b1;
                    default:     pattern <= pattern;
                endcase
            end

            case (mode_q)
                MODE_MIRROR: bus.led <= bus.sw_data;
                MODE_BLINK:  bus.led <= phase ? pattern : '0;
                default:     bus.led <= pattern;
            endcase
        end
    end

endmodule

// File: tb/tb_led_mode_controller.sv
// tb/tb_led_mode_controller.sv - scoreboard bench for led_mode_controller with TICK_DIV=4
`timescale 1ns/1ps
module tb_led_mode_controller;
    import led_ctrl_pkg::*;

    localparam int WIDTH    = 10;
    localparam int TICK_DIV = 4;

    typedef struct {
        int         cyc;
        logic [9:0] led;
        bit         chk_tick;
        logic       tick;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_cnt  = 0;
    exp_t sbq[$];
    exp_t cur;

    led_mode_controller_if #(.WIDTH(WIDTH)) bus ();

    led_mode_controller #(
        .WIDTH    (WIDTH),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int d, input logic [9:0] v, input bit ct, input logic t, input string nm);
        exp_t e;
        int   i;
        e.cyc      = cyc + d;
        e.led      = v;
        e.chk_tick = ct;
        e.tick     = t;
        e.name     = nm;
        i = sbq.size();
        while (i > 0 && sbq[i-1].cyc > e.cyc) i--;
        sbq.insert(i, e);
    endtask

    task automatic expl(input int d, input logic [9:0] v, input string nm);
        push(d, v, 1'b0, 1'b0, nm);
    endtask

    task automatic expt(input int d, input logic [9:0] v, input logic t, input string nm);
        push(d, v, 1'b1, t, nm);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic summary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    endtask

    // Monitor: outputs are sampled on the falling edge, after the edge counted by cyc.
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            cur = sbq.pop_front();
            n_checks++;
            if (cur.cyc != cyc) begin
                n_fail++;
                $display("FAIL %s: check for cycle %0d reached only at cycle %0d", cur.name, cur.cyc, cyc);
            end else if (bus.led !== cur.led) begin
                n_fail++;
                $display("FAIL %s: cycle %0d led actual=0x%03h required=0x%03h", cur.name, cyc, bus.led, cur.led);
            end else if (cur.chk_tick && bus.tick !== cur.tick) begin
                n_fail++;
                $display("FAIL %s: cycle %0d tick actual=%b required=%b", cur.name, cyc, bus.tick, cur.tick);
            end
        end
    end

    initial begin
        #500000;
        n_checks++;
        n_fail++;
        $display("FAIL timeout: stimulus did not complete by %0t", $time);
        summary();
        $finish;
    end

    initial begin
        rst_n          = 1'b0;
        bus.sw_data    = 10'h3FF;
        bus.mode       = MODE_MIRROR;
        bus.auto_en    = 1'b0;
        bus.step_btn_n = 1'b1;

        // Reset
        expt(1, 10'h000, 1'b0, "reset_edge1");
        expt(2, 10'h000, 1'b0, "reset_edge2");
        wait_cyc(2);
        rst_n = 1'b1;
        expl(1, 10'h3FF, "reset_release_mirror");
        wait_cyc(1);

        // Mirror latency, step and tick activity ignored
        bus.sw_data = 10'h000;
        expl(1, 10'h000, "mirror_zero");
        wait_cyc(1);
        bus.sw_data = 10'h2AA;
        expl(1, 10'h2AA, "mirror_2aa");
        wait_cyc(1);
        bus.auto_en    = 1'b1;
        bus.step_btn_n = 1'b0;
        for (int d = 1; d <= 8; d++) expl(d, 10'h2AA, "mirror_ignores_advance");
        wait_cyc(3);
        bus.step_btn_n = 1'b1;
        wait_cyc(5);

        // Chase, left rotation then reversal
        bus.sw_data = 10'h000;
        bus.mode    = MODE_CHASE;
        expl(2, 10'h001, "chase_entry");
        expt(5, 10'h001, 1'b1, "chase_tick_pulse");
        expt(6, 10'h002, 1'b0, "chase_tick_clear");
        for (int k = 1; k <= 10; k++) expl(2 + 4 * k, 10'(1 << (k % 10)), "chase_rotate_left");
        wait_cyc(42);
        bus.sw_data = 10'h200;
        expl(4, 10'h200, "chase_rotate_right_wrap");
        wait_cyc(4);

        // Reset mid-chase
        rst_n = 1'b0;
        expt(1, 10'h000, 1'b0, "reset_mid_chase");
        wait_cyc(1);
        rst_n    = 1'b1;
        bus.mode = MODE_MIRROR;
        expl(1, 10'h200, "mirror_after_reset");
        wait_cyc(2);

        // Blink with snapshot, then re-entry
        bus.sw_data = 10'h155;
        bus.mode    = MODE_BLINK;
        for (int k = 0; k <= 5; k++) expl(2 + 4 * k, (k % 2 == 0) ? 10'h155 : 10'h000, "blink_toggle");
        wait_cyc(8);
        bus.sw_data = 10'h0F0;
        wait_cyc(14);
        bus.mode = MODE_MIRROR;
        wait_cyc(1);
        bus.mode = MODE_BLINK;
        expl(2, 10'h0F0, "blink_reentry_snapshot");
        expl(6, 10'h000, "blink_reentry_off");
        wait_cyc(6);

        // Count via manual steps, full wrap
        bus.auto_en = 1'b0;
        bus.mode    = MODE_COUNT;
        exp_cnt     = 0;
        expl(2, 10'h000, "count_entry");
        wait_cyc(3);
        for (int i = 1; i <= 1024; i++) begin
            bus.step_btn_n = 1'b0;
            exp_cnt = (exp_cnt + 1) % 1024;
            if (exp_cnt == 1023)    expl(4, 10'(exp_cnt), "count_all_ones");
            else if (exp_cnt == 0)  expl(4, 10'(exp_cnt), "count_wrap_zero");
            else                    expl(4, 10'(exp_cnt), "count_step");
            wait_cyc(3);
            bus.step_btn_n = 1'b1;
            wait_cyc(3);
        end

        // Held button gives a single step
        bus.step_btn_n = 1'b0;
        exp_cnt = (exp_cnt + 1) % 1024;
        expl(4, 10'(exp_cnt), "hold_first_step");
        expl(20, 10'(exp_cnt), "hold_no_repeat");
        wait_cyc(20);
        bus.step_btn_n = 1'b1;
        expl(6, 10'(exp_cnt), "release_no_step");
        wait_cyc(6);

        // Step coincident with tick: one increment
        bus.auto_en = 1'b1;
        expl(5, 10'((exp_cnt + 1) % 1024), "count_tick_1");
        expl(9, 10'((exp_cnt + 2) % 1024), "count_tick_and_step_single");
        expl(13, 10'((exp_cnt + 3) % 1024), "count_tick_3");
        wait_cyc(5);
        bus.step_btn_n = 1'b0;
        wait_cyc(3);
        bus.step_btn_n = 1'b1;
        wait_cyc(5);
        exp_cnt = (exp_cnt + 3) % 1024;

        // Mode change during a tick cycle: entry value, no advance, prescaler restarts
        wait_cyc(2);
        bus.sw_data = 10'h000;
        bus.mode    = MODE_CHASE;
        expt(1, 10'(exp_cnt), 1'b1, "modechg_no_count_advance");
        expt(2, 10'h001, 1'b0, "modechg_entry");
        expt(4, 10'h001, 1'b0, "modechg_no_early_tick");
        expt(5, 10'h001, 1'b1, "modechg_next_tick");
        expl(6, 10'h002, "modechg_advance_after_4");
        wait_cyc(8);

        wait_cyc(3);
        if (sbq.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d scheduled checks left, required 0", sbq.size());
        end
        summary();
        $finish;
    end

endmodule

// File: doc/led_mode_controller.md
Name: led_mode_controller

Overview:
Sequencer that owns the board LED bank and drives it from the slide switches in one of four selectable modes: mirror, chase, blink and binary count.
- Advances come from an internal prescaler tick or a manual push-button step.
- Sits between the board switches/keys and LEDR, replacing the direct switch-to-LED wiring in the lab top level.

Parameters:
WIDTH, 10, number of switches/LEDs.
TICK_DIV, 12_500_000, clock cycles per auto-advance (4 Hz at 50 MHz); must be >= 2; benches use 4.

Ports:
clk  input  1  system clock (50 MHz on board).
rst_n  input  1  reset; synchronous, active-low.
sw_data  input  WIDTH  switch values, already stable (no sync required).
mode  input  2  mode select (mode_t encoding).
auto_en  input  1  1 = prescaler ticks advance the pattern.
step_btn_n  input  1  asynchronous push-button, active-low; one falling edge = one manual advance.
led  output  WIDTH  registered LED drive.
tick  output  1  registered one-cycle pulse per prescaler wrap, for debug.

Behaviour:
- Reset, while rst_n=0 at a clk edge:
  - led=0, tick=0, prescaler=0, pattern=0, phase=1.
  - Current mode register = MODE_MIRROR; button sync flops = 1.
  - Reset asserted mid-operation aborts everything at that edge; no partial state survives.
- Prescaler (tick_prescaler):
  - Counts 0..TICK_DIV-1 while auto_en=1, then wraps to 0.
  - tick_raw=1 in the cycle where count==TICK_DIV-1.
  - auto_en=0: count held at 0, no ticks.
  - The tick output is tick_raw registered.
- Step path:
  - step_btn_n passes through a 2-flop synchronizer, then a falling-edge detect gives step_pulse (1 cycle).
  - The LED change is visible 3 edges after step_btn_n is first sampled low.
  - Holding the button produces no further steps.
- Advance: advance = tick_raw | step_pulse. Simultaneous sources give a single advance.
- Mode change:
  - Detected when mode != mode_q. Handled in that cycle:
    - mode_q updates.
    - Pattern is loaded with the entry value.
    - Prescaler is cleared to 0.
    - Any advance in that cycle is discarded.
- Per-mode operation (pattern and led update on the edge where advance=1, or every edge in MIRROR):
  - MIRROR: led <= sw_data every cycle (1-cycle latency); advance ignored.
  - CHASE: entry pattern = 1 (bit 0).
    - Advance with sw_data[WIDTH-1]=0: rotate left, bit WIDTH-1 wraps to bit 0.
    - Advance with sw_data[WIDTH-1]=1: rotate right, bit 0 wraps to bit WIDTH-1.
    - Exactly one bit is always set.
    - led <= pattern.
  - BLINK: entry pattern = snapshot of sw_data, phase=1.
    - Advance toggles phase.
    - led <= phase ? pattern : 0.
    - Later sw_data changes are ignored until re-entry.
  - COUNT: entry pattern = 0.
    - Advance does pattern+1 modulo 2^WIDTH (all-ones wraps to 0, no saturation).
    - led <= pattern.
- Output timing:
  - In every mode other than MIRROR, led always equals the value the mode rule gives for the current registers, one cycle after they change.
  - No combinational path from any input to led.

Decomposition:
- Package led_ctrl_pkg holds:
  - typedef enum logic [1:0] mode_t {MODE_MIRROR=0, MODE_CHASE=1, MODE_BLINK=2, MODE_COUNT=3}.
  - Localparams for the reset/entry values: CHASE_SEED=1, BLINK_PHASE_INIT=1.
- Sub-module tick_prescaler (parameter TICK_DIV):
  - Ports clk, rst_n, en, clr, tick.
  - Instantiated once.
- Synchronizer, edge detect, mode FSM and pattern datapath stay in led_mode_controller.

Test Plan (TICK_DIV=4):
1. Reset: hold rst_n=0 for 2 cycles with sw_data=0x3FF, mode=MIRROR -> led=0x000, tick=0 during reset; led=0x3FF one cycle after release.
2. Mirror latency: sw_data 0x000 -> 0x2AA -> led=0x2AA on the next edge; step/tick activity causes no change.
3. Chase, auto_en=1, sw_data[9]=0:
   - Entry gives led=0x001.
   - Then 0x002, 0x004 … 0x200 at 4-cycle spacing; back to 0x001 after 10 ticks.
   - Set sw_data[9]=1 at 0x001 -> next tick gives 0x200.
4. Blink: sw_data=0x155 at entry -> led alternates 0x155/0x000 every 4 cycles; changing sw_data to 0x0F0 mid-blink leaves 0x155; re-entering BLINK loads 0x0F0.
5. Count, manual step, auto_en=0:
   - Each step_btn_n low pulse (>=3 cycles) increments led by 1, visible 3 edges after the fall.
   - After 1023 steps led=0x3FF; the 1024th step gives 0x000.
   - Holding the button gives exactly one increment.
6. Simultaneous events:
   - step_pulse coincident with tick_raw in COUNT -> single increment.
   - Mode change in a tick_raw cycle -> entry value loaded, no advance, next tick exactly 4 cycles later.
   - rst_n=0 mid-chase -> led=0x000 at that edge.
